// File: rtl/led_pkg.sv
// Shared definitions for the LED serial link (receiver side, shared constants
// with the transmitter).
//   recv_state_t : receiver frame-tracking states
//   led_word_t   : field view of one 32-bit LED frame word
//   ERR_*        : err_code values
package led_pkg;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned BRIGHT_W = 5;
   localparam int unsigned DATA_W   = 24;
   localparam int unsigned ZCNT_W   = 6;
   localparam int unsigned BCNT_W   = 5;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      ALIGN = 2'd1,
      LED   = 2'd2,
      END   = 2'd3
   } recv_state_t;

   localparam logic [1:0] ERR_HDR = 2'd1;
   localparam logic [1:0] ERR_END = 2'd2;
   localparam logic [1:0] ERR_TMO = 2'd3;

   localparam logic [WORD_W-1:0] START_WORD = 32'h0000_0000;
   localparam logic [WORD_W-1:0] END_WORD   = 32'hFFFF_FFFF;
   localparam logic [2:0]        HDR        = 3'b111;

   // One LED frame: 3-bit header, 5-bit brightness, {BLUE, GREEN, RED}
   typedef struct packed {
      logic [2:0]          hdr;
      logic [BRIGHT_W-1:0] bright;
      logic [DATA_W-1:0]   bgr;
   } led_word_t;

endpackage

// File: rtl/led_recv_sync.sv
// Brings the link clock/data into the clk domain and flags cki rising edges.
//   clk, rst : system clock, synchronous active-high reset
//   cki_i    : raw serial clock from the link
//   sdi_i    : raw serial data from the link
//   rise_o   : one clk high per synchronized cki rising edge
//   bit_o    : synchronized data, valid to sample while rise_o is high
module led_recv_sync (
   input  logic clk,
   input  logic rst,
   input  logic cki_i,
   input  logic sdi_i,
   output logic rise_o,
   output logic bit_o
);

   logic cki_s1_q, cki_s2_q, cki_s3_q;
   logic sdi_s1_q, sdi_s2_q;

   // Two-flop synchronizers; third cki flop gives the previous level
   always_ff @(posedge clk) begin
      if (rst) begin
         cki_s1_q <= 1'b0;
         cki_s2_q <= 1'b0;
         cki_s3_q <= 1'b0;
         sdi_s1_q <= 1'b0;
         sdi_s2_q <= 1'b0;
      end else begin
         cki_s1_q <= cki_i;
         cki_s2_q <= cki_s1_q;
         cki_s3_q <= cki_s2_q;
         sdi_s1_q <= sdi_i;
         sdi_s2_q <= sdi_s1_q;
      end
   end

   // sdi and cki share the same synchronizer depth, so sdi_s2 is aligned
   assign rise_o = cki_s2_q & ~cki_s3_q;
   assign bit_o  = sdi_s2_q;

endmodule

// File: rtl/led_recv.sv
// LED serial link receiver: finds the zero start frame, deserializes LED_NUM
// LED words and checks the all-ones end frame.
//   clk, rst    : 150 MHz system clock, synchronous active-high reset
//   cki, sdi    : serial clock/data from the link (async to clk)
//   led_valid   : pulse, LED frame decoded (led_bright/led_data/led_idx)
//   frame_done  : pulse, valid end frame received (led_count updated)
//   err         : pulse, protocol error; err_code held until the next err
//   busy        : high while a frame is being tracked
module led_recv
   import led_pkg::*;
#(
   parameter int unsigned LED_NUM     = 4,
   parameter int unsigned TIMEOUT_CNT = 64,
   parameter int unsigned IDX_W       = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cki,
   input  logic                sdi,
   output logic                led_valid,
   output logic [BRIGHT_W-1:0] led_bright,
   output logic [DATA_W-1:0]   led_data,
   output logic [IDX_W-1:0]    led_idx,
   output logic                frame_done,
   output logic [IDX_W-1:0]    led_count,
   output logic                err,
   output logic [1:0]          err_code,
   output logic                busy
);

   localparam int unsigned IDLE_W = $clog2(TIMEOUT_CNT + 1);

   logic rise;
   logic sbit;

   led_recv_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .cki_i  (cki),
      .sdi_i  (sdi),
      .rise_o (rise),
      .bit_o  (sbit)
   );

   recv_state_t         state_q;
   logic [ZCNT_W-1:0]   zero_cnt_q;
   logic [BCNT_W-1:0]   bit_cnt_q;
   logic [IDX_W-1:0]    led_cnt_q;
   logic [IDLE_W-1:0]   idle_cnt_q;
   logic [WORD_W-1:0]   word_q;
   logic                word_rdy_q;

   logic                led_valid_q;
   logic [BRIGHT_W-1:0] led_bright_q;
   logic [DATA_W-1:0]   led_data_q;
   logic [IDX_W-1:0]    led_idx_q;
   logic                frame_done_q;
   logic [IDX_W-1:0]    led_count_q;
   logic                err_q;
   logic [1:0]          err_code_q;
   logic                busy_q;

   led_word_t w;
   assign w = led_word_t'(word_q);

   // Frame tracker and deserializer. A completed word is registered first and
   // judged on the following clk (word_rdy_q); cki phases of >= 2 clk keep a
   // new rise from landing in that judging cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= HUNT;
         zero_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         led_cnt_q    <= '0;
         idle_cnt_q   <= '0;
         word_q       <= '0;
         word_rdy_q   <= 1'b0;
         led_valid_q  <= 1'b0;
         led_bright_q <= '0;
         led_data_q   <= '0;
         led_idx_q    <= '0;
         frame_done_q <= 1'b0;
         led_count_q  <= '0;
         err_q        <= 1'b0;
         err_code_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         led_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;

         // Clocks since the last rise; only meaningful outside HUNT
         if (rise || state_q == HUNT) begin
            idle_cnt_q <= '0;
         end else begin
            idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
         end

         if (word_rdy_q) begin
            word_rdy_q <= 1'b0;
            if (state_q == LED) begin
               if (w.hdr != HDR) begin
                  err_q      <= 1'b1;
                  err_code_q <= ERR_HDR;
                  state_q    <= HUNT;
                  busy_q     <= 1'b0;
                  zero_cnt_q <= '0;
                  bit_cnt_q  <= '0;
                  led_cnt_q  <= '0;
                  idle_cnt_q <= '0;
               end else begin
                  led_valid_q  <= 1'b1;
                  led_bright_q <= w.bright;
                  led_data_q   <= w.bgr;
                  led_idx_q    <= led_cnt_q;
                  led_cnt_q    <= led_cnt_q + IDX_W'(1);
                  if (led_cnt_q == IDX_W'(LED_NUM - 1)) begin
                     state_q <= END;
                  end
               end
            end else begin
               if (word_q == END_WORD) begin
                  frame_done_q <= 1'b1;
                  led_count_q  <= IDX_W'(LED_NUM);
               end else begin
                  err_q      <= 1'b1;
                  err_code_q <= ERR_END;
               end
               state_q    <= HUNT;
               busy_q     <= 1'b0;
               zero_cnt_q <= '0;
               bit_cnt_q  <= '0;
               led_cnt_q  <= '0;
               idle_cnt_q <= '0;
            end
         end else if (rise) begin
            case (state_q)
               HUNT: begin
                  if (sbit) begin
                     zero_cnt_q <= '0;
                  end else if (zero_cnt_q == ZCNT_W'(31)) begin
                     zero_cnt_q <= '0;
                     state_q    <= ALIGN;
                     busy_q     <= 1'b1;
                  end else begin
                     zero_cnt_q <= zero_cnt_q + ZCNT_W'(1);
                  end
               end
               ALIGN: begin
                  // Extra start zeros are absorbed; the first 1 is bit 31
                  if (sbit) begin
                     word_q    <= {START_WORD[WORD_W-2:0], 1'b1};
                     bit_cnt_q <= BCNT_W'(1);
                     state_q   <= LED;
                  end
               end
               default: begin
                  word_q    <= {word_q[WORD_W-2:0], sbit};
                  bit_cnt_q <= bit_cnt_q + BCNT_W'(1);
                  if (bit_cnt_q == BCNT_W'(WORD_W - 1)) begin
                     word_rdy_q <= 1'b1;
                  end
               end
            endcase
         end else if (state_q != HUNT && idle_cnt_q == IDLE_W'(TIMEOUT_CNT - 1)) begin
            // Link clock stalled mid-frame: abandon it
            err_q      <= 1'b1;
            err_code_q <= ERR_TMO;
            state_q    <= HUNT;
            busy_q     <= 1'b0;
            zero_cnt_q <= '0;
            bit_cnt_q  <= '0;
            led_cnt_q  <= '0;
            idle_cnt_q <= '0;
         end
      end
   end

   assign led_valid  = led_valid_q;
   assign led_bright = led_bright_q;
   assign led_data   = led_data_q;
   assign led_idx    = led_idx_q;
   assign frame_done = frame_done_q;
   assign led_count  = led_count_q;
   assign err        = err_q;
   assign err_code   = err_code_q;
   assign busy       = busy_q;

endmodule
